// File: rtl/uart_rx_bit_sequencer.sv
// ============================================================================
// uart_rx_bit_sequencer
// ----------------------------------------------------------------------------
// Receive-side bit sequencer for the UART. It combines the bit-time counter
// and the bit counter. A start-edge request launches a frame. The block then
// produces a strobe at the centre of each bit, together with the index of
// that bit. At the end of the frame it emits a one-cycle done pulse. It also
// reports false starts (line high at the start-bit centre) and framing
// errors (a stop bit sampled low).
//
// Ports:
//   clk             system clock
//   reset           asynchronous, active-high reset
//   i_start         start edge seen on the rx line; accepted only in IDLE
//   i_abort         synchronous abort; returns to IDLE without done
//   i_rx_in         synchronised serial input, used on sample strobes
//   i_baud_div      clocks per bit; values below 2 behave as 2
//   i_data_bits     00=5, 01=6, 10=7, 11=8 data bits
//   i_parity_en     frame carries a parity bit
//   i_stop2         frame carries two stop bits
//   o_busy          high in START, BITS and DONE
//   o_sample        one-cycle strobe at bit centre
//   o_bit_idx       index of bit being sampled (0=start, data, parity, stops)
//   o_frame_len     latched total bit count of the current frame
//   o_done          one-cycle pulse when the frame is complete
//   o_false_start   one-cycle pulse, line high at start-bit centre
//   o_frame_err     valid with o_done; a stop sample was 0
//
// Handshake: i_start is a single-cycle request with no ready. It is taken
// only while o_busy is low. All outputs are decoded from registered state.
// The only exception is o_false_start, which also qualifies the strobe with
// the live i_rx_in.
// ============================================================================
module uart_rx_bit_sequencer #(
    parameter int BAUD_W = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_rx_in,
    input  logic [BAUD_W-1:0] i_baud_div,
    input  logic [1:0]        i_data_bits,
    input  logic              i_parity_en,
    input  logic              i_stop2,
    output logic              o_busy,
    output logic              o_sample,
    output logic [IDX_W-1:0]  o_bit_idx,
    output logic [IDX_W-1:0]  o_frame_len,
    output logic              o_done,
    output logic              o_false_start,
    output logic              o_frame_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_BITS  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]        r_state;
    logic [BAUD_W-1:0] r_bt_cnt;
    logic [IDX_W-1:0]  r_bit_idx;
    logic [IDX_W-1:0]  r_frame_len;
    logic [BAUD_W-1:0] r_div;
    logic [BAUD_W-1:0] r_half;
    logic              r_stop2;
    logic              r_err;

    logic [BAUD_W-1:0] w_div_clamped;
    logic [IDX_W-1:0]  w_frame_len_cfg;
    logic              w_start_hit;
    logic              w_bits_hit;
    logic              w_last_bit;
    logic              w_stop_bit;

    // A divisor below 2 would leave no half-bit interval for the start-bit
    // centre, so 0 and 1 are raised to 2.
    assign w_div_clamped = (i_baud_div < BAUD_W'(2)) ? BAUD_W'(2) : i_baud_div;

    // start + (5 + data_bits) + parity + stop + optional second stop.
    assign w_frame_len_cfg = IDX_W'(7) + IDX_W'(i_data_bits)
                           + IDX_W'(i_parity_en) + IDX_W'(i_stop2);

    assign w_start_hit = (r_state == S_START) && (r_bt_cnt == r_half - BAUD_W'(1));
    assign w_bits_hit  = (r_state == S_BITS)  && (r_bt_cnt == r_div  - BAUD_W'(1));
    assign w_last_bit  = (r_bit_idx == r_frame_len - IDX_W'(1));

    // The stop bits are the final one or two indices of the frame.
    assign w_stop_bit  = (r_bit_idx >= r_frame_len - IDX_W'(1) - IDX_W'(r_stop2));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_bt_cnt    <= '0;
            r_bit_idx   <= '0;
            r_frame_len <= '0;
            r_div       <= '0;
            r_half      <= '0;
            r_stop2     <= 1'b0;
            r_err       <= 1'b0;
        end else if (i_abort && (r_state != S_IDLE)) begin
            r_state   <= S_IDLE;
            r_bt_cnt  <= '0;
            r_bit_idx <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state     <= S_START;
                        r_bt_cnt    <= '0;
                        r_bit_idx   <= '0;
                        r_err       <= 1'b0;
                        r_frame_len <= w_frame_len_cfg;
                        r_div       <= w_div_clamped;
                        r_half      <= w_div_clamped >> 1;
                        r_stop2     <= i_stop2;
                    end
                end
                S_START: begin
                    if (w_start_hit) begin
                        r_bt_cnt <= '0;
                        if (i_rx_in) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state   <= S_BITS;
                            r_bit_idx <= IDX_W'(1);
                        end
                    end else begin
                        r_bt_cnt <= r_bt_cnt + BAUD_W'(1);
                    end
                end
                S_BITS: begin
                    if (w_bits_hit) begin
                        r_bt_cnt <= '0;
                        if (w_stop_bit && !i_rx_in) begin
                            r_err <= 1'b1;
                        end
                        if (w_last_bit) begin
                            r_state <= S_DONE;
                        end else begin
                            r_bit_idx <= r_bit_idx + IDX_W'(1);
                        end
                    end else begin
                        r_bt_cnt <= r_bt_cnt + BAUD_W'(1);
                    end
                end
                S_DONE: begin
                    r_state   <= S_IDLE;
                    r_bt_cnt  <= '0;
                    r_bit_idx <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_busy        = (r_state != S_IDLE);
    assign o_sample      = w_start_hit || w_bits_hit;
    assign o_bit_idx     = r_bit_idx;
    assign o_frame_len   = r_frame_len;
    assign o_done        = (r_state == S_DONE);
    assign o_false_start = w_start_hit && i_rx_in;
    assign o_frame_err   = (r_state == S_DONE) && r_err;

endmodule
